// File: rtl/life_pkg.sv
// Shared types and default geometry for the life engine blocks.
package life_pkg;

    localparam int LIFE_ADDR_W = 12;
    localparam int LIFE_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        SWAP  = 3'd2,
        CLEAR = 3'd3,
        READY = 3'd4
    } buf_state_t;

    function automatic logic other_bank(input logic bank);
        return ~bank;
    endfunction

endpackage

// File: rtl/buf_manager_if.sv
// Buffer-swap handshake plus the logic and render memory ports of the board store.
interface buf_manager_if
    import life_pkg::*;
#(
    parameter int ADDR_W = LIFE_ADDR_W,
    parameter int DATA_W = LIFE_DATA_W
);

    logic              buf_swap_in;
    logic              buf_ready_out;
    logic [ADDR_W-1:0] logic_raddr_in;
    logic [DATA_W-1:0] logic_rdata_out;
    logic              logic_we_in;
    logic [ADDR_W-1:0] logic_waddr_in;
    logic [DATA_W-1:0] logic_wdata_in;
    logic [ADDR_W-1:0] render_raddr_in;
    logic [DATA_W-1:0] render_rdata_out;
    logic              read_bank_out;
    logic              busy_out;
    logic              swap_err_out;

    modport master (
        output buf_swap_in, logic_raddr_in, logic_we_in, logic_waddr_in,
               logic_wdata_in, render_raddr_in,
        input  buf_ready_out, logic_rdata_out, render_rdata_out,
               read_bank_out, busy_out, swap_err_out
    );

    modport slave (
        input  buf_swap_in, logic_raddr_in, logic_we_in, logic_waddr_in,
               logic_wdata_in, render_raddr_in,
        output buf_ready_out, logic_rdata_out, render_rdata_out,
               read_bank_out, busy_out, swap_err_out
    );

endinterface

// File: rtl/bank_ram.sv
// One cell-memory bank: single write port, two read ports, each with an
// RD_LAT-deep output pipeline (first stage is the registered RAM read).
module bank_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              we_in,
    input  logic [ADDR_W-1:0] waddr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [ADDR_W-1:0] raddr_a_in,
    input  logic [ADDR_W-1:0] raddr_b_in,
    output logic [DATA_W-1:0] rdata_a_out,
    output logic [DATA_W-1:0] rdata_b_out
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] raddr [2];
    logic [DATA_W-1:0] rdata [2];

    assign raddr[0]    = raddr_a_in;
    assign raddr[1]    = raddr_b_in;
    assign rdata_a_out = rdata[0];
    assign rdata_b_out = rdata[1];

    always_ff @(posedge clk_in) begin
        if (we_in) begin
            mem_q[waddr_in] <= wdata_in;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_W-1:0] pipe_q [RD_LAT];

            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    for (int i = 0; i < RD_LAT; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q[0] <= mem_q[raddr[gi]];
                    for (int i = 1; i < RD_LAT; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign rdata[gi] = pipe_q[RD_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/buf_manager.sv
// Double-buffered board store: both readers see the current bank, the logic
// engine writes the other; a swap request drains reads, flips, optionally clears.
module buf_manager
    import life_pkg::*;
#(
    parameter int ADDR_W        = LIFE_ADDR_W,
    parameter int DATA_W        = LIFE_DATA_W,
    parameter int RD_LAT        = 2,
    parameter int CLEAR_ON_SWAP = 0
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    buf_manager_if.slave  bus
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(RD_LAT - 1);

    buf_state_t        state_q, state_d;
    logic              read_bank_q, read_bank_d;
    logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              swap_err_q, swap_err_d;
    logic [RD_LAT-1:0] rd_sel_q;

    logic              write_bank;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              bank_we  [2];
    logic [DATA_W-1:0] bank_lrd [2];
    logic [DATA_W-1:0] bank_rrd [2];

    always_comb begin
        state_d     = state_q;
        read_bank_d = read_bank_q;
        drain_cnt_d = drain_cnt_q;
        clr_addr_d  = clr_addr_q;
        swap_err_d  = swap_err_q;

        case (state_q)
            IDLE: begin
                if (bus.buf_swap_in) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = SWAP;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            SWAP: begin
                read_bank_d = other_bank(read_bank_q);
                clr_addr_d  = '0;
                state_d     = (CLEAR_ON_SWAP != 0) ? CLEAR : READY;
            end
            CLEAR: begin
                if (clr_addr_q == '1) begin
                    state_d = READY;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            READY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A request arriving mid-swap (READY included) is dropped and flagged.
        if (bus.buf_swap_in && (state_q != IDLE)) begin
            swap_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            read_bank_q <= 1'b0;
            drain_cnt_q <= '0;
            clr_addr_q  <= '0;
            swap_err_q  <= 1'b0;
            rd_sel_q    <= '0;
        end else begin
            state_q     <= state_d;
            read_bank_q <= read_bank_d;
            drain_cnt_q <= drain_cnt_d;
            clr_addr_q  <= clr_addr_d;
            swap_err_q  <= swap_err_d;
            // Bank choice travels with each read so in-flight data stays on its bank.
            rd_sel_q[0] <= read_bank_q;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_sel_q[i] <= rd_sel_q[i-1];
            end
        end
    end

    assign write_bank = other_bank(read_bank_q);
    assign wr_en      = ((state_q == IDLE) && bus.logic_we_in) || (state_q == CLEAR);
    assign wr_addr    = (state_q == CLEAR) ? clr_addr_q : bus.logic_waddr_in;
    assign wr_data    = (state_q == CLEAR) ? '0 : bus.logic_wdata_in;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            assign bank_we[gi] = wr_en && (write_bank == 1'(gi));

            bank_ram #(
                .ADDR_W (ADDR_W),
                .DATA_W (DATA_W),
                .RD_LAT (RD_LAT)
            ) u_bank (
                .clk_in      (clk_in),
                .rst_n_in    (rst_n_in),
                .we_in       (bank_we[gi]),
                .waddr_in    (wr_addr),
                .wdata_in    (wr_data),
                .raddr_a_in  (bus.logic_raddr_in),
                .raddr_b_in  (bus.render_raddr_in),
                .rdata_a_out (bank_lrd[gi]),
                .rdata_b_out (bank_rrd[gi])
            );
        end
    endgenerate

    assign bus.logic_rdata_out  = rd_sel_q[RD_LAT-1] ? bank_lrd[1] : bank_lrd[0];
    assign bus.render_rdata_out = rd_sel_q[RD_LAT-1] ? bank_rrd[1] : bank_rrd[0];
    assign bus.buf_ready_out    = (state_q == READY);
    assign bus.busy_out         = (state_q != IDLE);
    assign bus.read_bank_out    = read_bank_q;
    assign bus.swap_err_out     = swap_err_q;

endmodule

// File: tb/tb_buf_manager.sv
// Directed bench for buf_manager: one instance without and one with clear-on-swap.
module tb_buf_manager;

    logic clk = 1'b0;
    logic rst0_n, rst1_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   first, cnt;
    logic [15:0] exp_q [$];
    logic [15:0] exp_arr [16];

    always #5 clk = ~clk;

    buf_manager_if #(.ADDR_W(4), .DATA_W(16)) if0 ();
    buf_manager_if #(.ADDR_W(4), .DATA_W(16)) if1 ();

    buf_manager #(.ADDR_W(4), .DATA_W(16), .RD_LAT(2), .CLEAR_ON_SWAP(0)) u_dut0 (
        .clk_in   (clk),
        .rst_n_in (rst0_n),
        .bus      (if0)
    );

    buf_manager #(.ADDR_W(4), .DATA_W(16), .RD_LAT(2), .CLEAR_ON_SWAP(1)) u_dut1 (
        .clk_in   (clk),
        .rst_n_in (rst1_n),
        .bus      (if1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_swap(input int d, input logic v);
        if (d == 0) if0.buf_swap_in = v;
        else        if1.buf_swap_in = v;
    endtask

    task automatic set_wr(input int d, input logic we, input logic [3:0] a, input logic [15:0] dt);
        if (d == 0) begin
            if0.logic_we_in = we; if0.logic_waddr_in = a; if0.logic_wdata_in = dt;
        end else begin
            if1.logic_we_in = we; if1.logic_waddr_in = a; if1.logic_wdata_in = dt;
        end
    endtask

    task automatic set_rd(input int d, input logic [3:0] la, input logic [3:0] ra);
        if (d == 0) begin
            if0.logic_raddr_in = la; if0.render_raddr_in = ra;
        end else begin
            if1.logic_raddr_in = la; if1.render_raddr_in = ra;
        end
    endtask

    function automatic logic [15:0] get_rd(input int d, input bit render);
        if (d == 0) return render ? if0.render_rdata_out : if0.logic_rdata_out;
        return render ? if1.render_rdata_out : if1.logic_rdata_out;
    endfunction

    // {swap_err, busy, read_bank, ready}
    function automatic logic [3:0] flags(input int d);
        if (d == 0) return {if0.swap_err_out, if0.busy_out, if0.read_bank_out, if0.buf_ready_out};
        return {if1.swap_err_out, if1.busy_out, if1.read_bank_out, if1.buf_ready_out};
    endfunction

    function automatic logic get_ready(input int d);
        return (d == 0) ? if0.buf_ready_out : if1.buf_ready_out;
    endfunction

    function automatic logic get_bank(input int d);
        return (d == 0) ? if0.read_bank_out : if1.read_bank_out;
    endfunction

    task automatic write_word(input int d, input logic [3:0] a, input logic [15:0] dt);
        set_wr(d, 1'b1, a, dt);
        tick();
        set_wr(d, 1'b0, 4'd0, 16'd0);
    endtask

    task automatic do_swap(input int d);
        set_swap(d, 1'b1);
        tick();
        set_swap(d, 1'b0);
    endtask

    task automatic wait_ready(input int d, input int max_cyc, output int first_c, output int n_pulse);
        first_c = -1;
        n_pulse = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (get_ready(d)) begin
                n_pulse++;
                if (first_c < 0) first_c = c;
            end
            tick();
        end
    endtask

    task automatic read_chk(input int d, input bit render, input logic [3:0] a,
                            input logic [15:0] exp, input string tag);
        if (render) set_rd(d, 4'd0, a);
        else        set_rd(d, a, 4'd0);
        exp_q.push_back(exp);
        tick();
        tick();
        @(negedge clk);
        check(tag, get_rd(d, render), exp_q.pop_front());
        tick();
    endtask

    task automatic read_all(input int d, input string tag);
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                set_rd(d, 4'd0, 4'(i));
                exp_q.push_back(exp_arr[i]);
            end
            @(negedge clk);
            if (i >= 2) check($sformatf("%s[%0d]", tag, i - 2), get_rd(d, 1'b1), exp_q.pop_front());
            tick();
        end
    endtask

    initial begin
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            set_swap(d, 1'b0);
            set_wr(d, 1'b0, 4'd0, 16'd0);
            set_rd(d, 4'd0, 4'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        rst0_n = 1'b1;
        rst1_n = 1'b1;

        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_flags%0d", d), flags(d), 4'b0000);
            check($sformatf("rst_lrd%0d", d), get_rd(d, 1'b0), 16'h0000);
            check($sformatf("rst_rrd%0d", d), get_rd(d, 1'b1), 16'h0000);
        end
        tick();

        // Swap timing: request in cycle 0, ready only in cycle 4.
        set_swap(0, 1'b1);
        @(negedge clk);
        check("sw_c0_busy", if0.busy_out, 1'b0);
        tick();
        set_swap(0, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("sw_ready_c%0d", c), if0.buf_ready_out, logic'(c == 4));
            check($sformatf("sw_bank_c%0d", c), if0.read_bank_out, logic'(c >= 4));
            if (c != 4) check($sformatf("sw_busy_c%0d", c), if0.busy_out, logic'(c <= 3));
            tick();
        end

        // Bank 0 is now the write bank.
        write_word(0, 4'd5, 16'hBEEF);
        write_word(0, 4'd3, 16'h1234);
        do_swap(0);
        wait_ready(0, 6, first, cnt);
        check("ws_ready_cycle", first, 4);
        check("ws_ready_count", cnt, 1);
        check("ws_bank", get_bank(0), 1'b0);
        read_chk(0, 1'b1, 4'd5, 16'hBEEF, "ws_render5");
        read_chk(0, 1'b0, 4'd5, 16'hBEEF, "ws_logic5");
        write_word(0, 4'd3, 16'h5678);

        // In-flight read across a swap, second request and write while draining.
        set_rd(0, 4'd0, 4'd3);
        exp_q.push_back(16'h1234);
        set_swap(0, 1'b1);
        tick();
        set_wr(0, 1'b1, 4'd3, 16'hDEAD);
        tick();
        set_swap(0, 1'b0);
        set_wr(0, 1'b0, 4'd0, 16'd0);
        @(negedge clk);
        check("inflight_old_bank", get_rd(0, 1'b1), exp_q.pop_front());
        check("err_set", if0.swap_err_out, 1'b1);
        tick();
        first = -1;
        cnt   = 0;
        for (int c = 3; c <= 8; c++) begin
            @(negedge clk);
            if (get_ready(0)) begin
                cnt++;
                if (first < 0) first = c;
            end
            tick();
        end
        check("dbl_ready_cycle", first, 4);
        check("dbl_ready_count", cnt, 1);
        check("dbl_bank", get_bank(0), 1'b1);
        read_chk(0, 1'b1, 4'd3, 16'h5678, "busy_write_ignored");
        check("err_sticky", if0.swap_err_out, 1'b1);

        // Asynchronous reset in the middle of DRAIN.
        do_swap(0);
        @(negedge clk);
        #2;
        rst0_n = 1'b0;
        #1;
        check("async_rst_flags", flags(0), 4'b0000);
        check("async_rst_rrd", get_rd(0, 1'b1), 16'h0000);
        @(posedge clk);
        #1;
        rst0_n = 1'b1;

        // Clear-on-swap instance.
        for (int i = 0; i < 16; i++) write_word(1, 4'(i), 16'hFFFF);
        do_swap(1);
        wait_ready(1, 22, first, cnt);
        check("clr_sw1_cycle", first, 20);
        do_swap(1);
        wait_ready(1, 22, first, cnt);
        check("clr_sw2_cycle", first, 20);
        check("clr_sw2_count", cnt, 1);
        check("clr_sw2_bank", get_bank(1), 1'b0);
        do_swap(1);
        wait_ready(1, 22, first, cnt);
        check("clr_sw3_bank", get_bank(1), 1'b1);
        for (int i = 0; i < 16; i++) exp_arr[i] = 16'h0000;
        read_all(1, "clr_zero");

        // Bank 0 gets a pattern, becomes current, then write bank again and is cleared.
        for (int i = 0; i < 16; i++) write_word(1, 4'(i), 16'hA5A5);
        do_swap(1);
        wait_ready(1, 22, first, cnt);
        do_swap(1);
        cnt = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (get_ready(1)) cnt++;
            tick();
        end
        rst1_n = 1'b0;
        #1;
        check("abort_flags", flags(1), 4'b0000);
        check("abort_no_ready", cnt, 0);
        @(negedge clk);
        tick();
        rst1_n = 1'b1;
        for (int i = 0; i < 16; i++) exp_arr[i] = (i < 7) ? 16'h0000 : 16'hA5A5;
        read_all(1, "abort_mem");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
